// File: rtl/assoc_cache_pkg.sv
// Shared types for the 2-way set-associative cache controller.
// Holds the default geometry, the FSM state encoding and the per-way line
// record. The line record's field widths follow the default geometry here,
// so the top-level width parameters must keep these defaults.
package assoc_cache_pkg;

    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_SET_BITS = 3;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_CNT_W    = 16;

    localparam int LINE_TAG_W   = DEF_ADDR_W - DEF_SET_BITS;
    localparam int LINE_DATA_W  = DEF_DATA_W;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_REFILL    = 3'd3,
        ST_WTHRU     = 3'd4,
        ST_RESPOND   = 3'd5
    } state_t;

    typedef struct packed {
        logic                   valid;
        logic                   dirty;
        logic [LINE_TAG_W-1:0]  tag;
        logic [LINE_DATA_W-1:0] data;
    } line_t;

endpackage

// File: rtl/cache_way.sv
// One way of the cache: SETS line entries, synchronous write, combinational
// read at the supplied index. Valid and dirty bits reset; tag and data do not.
module cache_way
    import assoc_cache_pkg::*;
#(
    parameter int SET_BITS = DEF_SET_BITS
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [SET_BITS-1:0] idx_i,
    output line_t               line_o,
    input  logic                wr_en_i,
    input  line_t               wr_line_i
);

    localparam int SETS = 2 ** SET_BITS;

    logic [SETS-1:0]        valid_q;
    logic [SETS-1:0]        dirty_q;
    logic [LINE_TAG_W-1:0]  tag_q  [SETS];
    logic [LINE_DATA_W-1:0] data_q [SETS];

    // Status bits: cleared by reset, written on a line install/update.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en_i) begin
            valid_q[idx_i] <= wr_line_i.valid;
            dirty_q[idx_i] <= wr_line_i.dirty;
        end
    end

    // Tag/data storage: written on install/update only.
    // NOTE: no reset on the storage arrays; a cleared valid bit already marks the contents as meaningless.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            tag_q[idx_i]  <= wr_line_i.tag;
            data_q[idx_i] <= wr_line_i.data;
        end
    end

    // Combinational read of the addressed entry.
    always_comb begin
        line_o.valid = valid_q[idx_i];
        line_o.dirty = dirty_q[idx_i];
        line_o.tag   = tag_q[idx_i];
        line_o.data  = data_q[idx_i];
    end

endmodule

// File: rtl/assoc_cache_ctrl.sv
// 2-way set-associative, one-word-line cache controller with LRU replacement
// and saturating hit/miss counters.
// Build option: define ASSOC_CACHE_WRITEBACK_EN for a write-back cache
// (dirty lines evicted through WRITEBACK). Left undefined, the cache is
// write-through/write-allocate: every write leaves through WTHRU.
module assoc_cache_ctrl
    import assoc_cache_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int SET_BITS = DEF_SET_BITS,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int SETS  = 2 ** SET_BITS;
    localparam int TAG_W = ADDR_W - SET_BITS;

`ifdef ASSOC_CACHE_WRITEBACK_EN
    localparam bit WRITEBACK_EN = 1'b1;
`else
    localparam bit WRITEBACK_EN = 1'b0;
`endif

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic              way_q;      // hit way or chosen victim, fixed in LOOKUP
    logic              hit_q;      // LOOKUP outcome, carried to RESPOND
    logic [SETS-1:0]   lru_q;      // per set: the way to evict next
    logic [DATA_W-1:0] resp_rdata_q;
    logic              resp_hit_q;
    logic [CNT_W-1:0]  hit_count_q;
    logic [CNT_W-1:0]  miss_count_q;

    logic [SET_BITS-1:0] idx;
    logic [TAG_W-1:0]    tag;
    line_t               line0, line1, sel_line, wr_line;
    logic                hit0, hit1, hit, hit_way, victim, sel_way;
    logic                wr_en, wr_way;
    logic [DATA_W-1:0]   hit_data, resp_data_d;
    logic                need_wb, wr_leaves_thru;

    assign idx = addr_q[SET_BITS-1:0];
    assign tag = addr_q[ADDR_W-1:SET_BITS];

    cache_way #(.SET_BITS(SET_BITS)) u_way0 (
        .clock     (clock),
        .reset     (reset),
        .idx_i     (idx),
        .line_o    (line0),
        .wr_en_i   (wr_en && !wr_way),
        .wr_line_i (wr_line)
    );

    cache_way #(.SET_BITS(SET_BITS)) u_way1 (
        .clock     (clock),
        .reset     (reset),
        .idx_i     (idx),
        .line_o    (line1),
        .wr_en_i   (wr_en && wr_way),
        .wr_line_i (wr_line)
    );

    // Tag compare, victim choice and the line the current state works on.
    always_comb begin
        hit0     = line0.valid && (line0.tag == tag);
        hit1     = line1.valid && (line1.tag == tag);
        hit      = hit0 || hit1;
        hit_way  = !hit0;                      // way 0 wins a double match
        hit_data = hit0 ? line0.data : line1.data;
        if (!line0.valid)      victim = 1'b0;
        else if (!line1.valid) victim = 1'b1;
        else                   victim = lru_q[idx];
        sel_way  = (state_q == ST_LOOKUP) ? victim : way_q;
        sel_line = sel_way ? line1 : line0;
        need_wb  = WRITEBACK_EN && sel_line.valid && sel_line.dirty;
        wr_leaves_thru = we_q && !WRITEBACK_EN;
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic.
    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (req_valid) state_d = ST_LOOKUP;
            ST_LOOKUP: begin
                if (hit)          state_d = wr_leaves_thru ? ST_WTHRU : ST_RESPOND;
                else if (need_wb) state_d = ST_WRITEBACK;
                else              state_d = ST_REFILL;
            end
            ST_WRITEBACK: if (mem_ack) state_d = ST_REFILL;
            ST_REFILL:    if (mem_ack) state_d = wr_leaves_thru ? ST_WTHRU : ST_RESPOND;
            ST_WTHRU:     if (mem_ack) state_d = ST_RESPOND;
            ST_RESPOND:   state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake, response strobe and backing-memory request.
    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        resp_valid = (state_q == ST_RESPOND);
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_q)
            ST_WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {sel_line.tag, idx};
                mem_wdata = sel_line.data;
            end
            ST_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
            end
            ST_WTHRU: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            default: ;
        endcase
    end

    // Line writes: data update on a write hit, full install on refill ack.
    always_comb begin
        wr_en   = 1'b0;
        wr_way  = 1'b0;
        wr_line = '0;
        if (state_q == ST_LOOKUP && hit && we_q) begin
            wr_en         = 1'b1;
            wr_way        = hit_way;
            wr_line.valid = 1'b1;
            wr_line.dirty = WRITEBACK_EN;
            wr_line.tag   = tag;
            wr_line.data  = wdata_q;
        end else if (state_q == ST_REFILL && mem_ack) begin
            wr_en         = 1'b1;
            wr_way        = way_q;
            wr_line.valid = 1'b1;
            wr_line.dirty = we_q && WRITEBACK_EN;
            wr_line.tag   = tag;
            wr_line.data  = we_q ? wdata_q : mem_rdata;
        end
    end

    // Data returned on the response, chosen by the state that leads to RESPOND.
    always_comb begin
        case (state_q)
            ST_LOOKUP: resp_data_d = we_q ? wdata_q : hit_data;
            ST_REFILL: resp_data_d = we_q ? wdata_q : mem_rdata;
            default:   resp_data_d = wdata_q;
        endcase
    end

    // Request capture, LOOKUP outcome and the held response fields.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            way_q        <= 1'b0;
            hit_q        <= 1'b0;
            resp_rdata_q <= '0;
            resp_hit_q   <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && req_valid) begin
                addr_q  <= req_addr;
                we_q    <= req_we;
                wdata_q <= req_wdata;
            end
            if (state_q == ST_LOOKUP) begin
                way_q <= hit ? hit_way : victim;
                hit_q <= hit;
            end
            if (state_d == ST_RESPOND && state_q != ST_RESPOND) begin
                resp_rdata_q <= resp_data_d;
                resp_hit_q   <= (state_q == ST_LOOKUP) ? hit : hit_q;
            end
        end
    end

    // LRU: point away from the way just hit or just installed.
    always_ff @(posedge clock) begin
        if (reset) begin
            lru_q <= '0;
        end else if (state_q == ST_LOOKUP && hit) begin
            lru_q[idx] <= !hit_way;
        end else if (state_q == ST_REFILL && mem_ack) begin
            lru_q[idx] <= !way_q;
        end
    end

    // Saturating statistics, one count per LOOKUP.
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else if (state_q == ST_LOOKUP) begin
            if (hit && hit_count_q != '1)
                hit_count_q <= hit_count_q + CNT_W'(1);
            if (!hit && miss_count_q != '1)
                miss_count_q <= miss_count_q + CNT_W'(1);
        end
    end

    assign resp_rdata = resp_rdata_q;
    assign resp_hit   = resp_hit_q;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Self-checking bench for assoc_cache_ctrl: a backing-memory responder with
// programmable ack delay, a response scoreboard queue and a log of memory
// transactions for ordering checks.
module tb_assoc_cache_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_valid, req_ready, req_we;
    logic [4:0] req_addr;
    logic [7:0] req_wdata;
    logic       resp_valid, resp_hit;
    logic [7:0] resp_rdata;
    logic       mem_req, mem_we, mem_ack;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic [15:0] hit_count, miss_count;

    always #5 clock = ~clock;

    assoc_cache_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_hit   (resp_hit),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    typedef struct { logic [7:0] data; logic hit; } exp_t;
    typedef struct { logic we; logic [4:0] addr; logic [7:0] data; } memop_t;

    exp_t       exp_q[$];
    memop_t     mem_log[$];
    logic [7:0] mem_mdl [32];
    int         n_vec = 0;
    int         n_err = 0;
    int         ack_delay = 0;
    bit         ack_hold = 1'b0;
    int         log_at_resp = 0;

    // Backing memory: acks one cycle per request after ack_delay idle cycles.
    initial begin
        int wait_cnt;
        wait_cnt  = 0;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clock);
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req && !ack_hold && !reset) begin
                if (wait_cnt >= ack_delay) begin
                    wait_cnt  = 0;
                    mem_ack   = 1'b1;
                    mem_rdata = mem_mdl[mem_addr];
                    mem_log.push_back('{mem_we, mem_addr, mem_wdata});
                    if (mem_we) mem_mdl[mem_addr] = mem_wdata;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        req_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        mem_log.delete();
    endtask

    // Drive one request until accepted; push its expected response.
    task automatic send_req(input logic we, input logic [4:0] addr, input logic [7:0] wdata,
                            input logic [7:0] exp_data, input logic exp_hit);
        int waited;
        @(negedge clock);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        waited    = 0;
        while (!req_ready && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        if (!req_ready) begin
            n_vec++; n_err++;
            $display("FAIL req_ready_timeout: req_ready=%0b required 1", req_ready);
        end
        exp_q.push_back('{exp_data, exp_hit});
        @(posedge clock);
        #1 req_valid = 1'b0;
    endtask

    // Wait for the response, pop the scoreboard and compare.
    task automatic wait_resp(output int lat);
        bit   got;
        exp_t e;
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clock);
            lat++;
            if (resp_valid) got = 1'b1;
        end
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL resp_timeout: no resp_valid within 200 cycles");
        end else if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL resp_unexpected: resp_valid with empty scoreboard");
        end else begin
            log_at_resp = mem_log.size();
            e = exp_q.pop_front();
            n_vec++;
            if (resp_rdata !== e.data) begin
                n_err++;
                $display("FAIL resp_rdata: got %h expected %h", resp_rdata, e.data);
            end
            n_vec++;
            if (resp_hit !== e.hit) begin
                n_err++;
                $display("FAIL resp_hit: got %b expected %b", resp_hit, e.hit);
            end
            @(negedge clock);
            n_vec++;
            if (resp_valid !== 1'b0) begin
                n_err++;
                $display("FAIL resp_pulse: resp_valid=%b expected 0 one cycle later", resp_valid);
            end
        end
    endtask

    task automatic do_req(input logic we, input logic [4:0] addr, input logic [7:0] wdata,
                          input logic [7:0] exp_data, input logic exp_hit, output int lat);
        send_req(we, addr, wdata, exp_data, exp_hit);
        wait_resp(lat);
    endtask

    task automatic wait_mem_req();
        int n;
        n = 0;
        while (!mem_req && n < 50) begin
            @(negedge clock);
            n++;
        end
        n_vec++;
        if (mem_req !== 1'b1) begin
            n_err++;
            $display("FAIL mem_req_timeout: mem_req=%b expected 1", mem_req);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        do_reset();
        n_vec++; if (req_ready !== 1'b1)   begin n_err++; $display("FAIL rst_req_ready: got %b expected 1", req_ready); end
        n_vec++; if (resp_valid !== 1'b0)  begin n_err++; $display("FAIL rst_resp_valid: got %b expected 0", resp_valid); end
        n_vec++; if (resp_hit !== 1'b0)    begin n_err++; $display("FAIL rst_resp_hit: got %b expected 0", resp_hit); end
        n_vec++; if (resp_rdata !== 8'h00) begin n_err++; $display("FAIL rst_resp_rdata: got %h expected 00", resp_rdata); end
        n_vec++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== 15'd0)
            begin n_err++; $display("FAIL rst_mem_outputs: req=%b we=%b addr=%h wdata=%h expected all 0", mem_req, mem_we, mem_addr, mem_wdata); end
        n_vec++; if (hit_count !== 16'd0 || miss_count !== 16'd0)
            begin n_err++; $display("FAIL rst_counters: hit=%0d miss=%0d expected 0/0", hit_count, miss_count); end
    endtask

    task automatic test_miss_then_hit();
        int lat;
        do_req(1'b0, 5'h0A, 8'h00, 8'h3C, 1'b0, lat);
        n_vec++; if (miss_count !== 16'd1 || hit_count !== 16'd0)
            begin n_err++; $display("FAIL miss_counts: hit=%0d miss=%0d expected 0/1", hit_count, miss_count); end
        do_req(1'b0, 5'h0A, 8'h00, 8'h3C, 1'b1, lat);
        n_vec++; if (lat != 2) begin n_err++; $display("FAIL hit_latency: got %0d cycles expected 2", lat); end
        n_vec++; if (hit_count !== 16'd1 || miss_count !== 16'd1)
            begin n_err++; $display("FAIL hit_counts: hit=%0d miss=%0d expected 1/1", hit_count, miss_count); end
        repeat (4) @(negedge clock);
        n_vec++; if (resp_rdata !== 8'h3C) begin n_err++; $display("FAIL rdata_hold: got %h expected 3c", resp_rdata); end
    endtask

    task automatic test_lru();
        int lat;
        do_reset();
        do_req(1'b0, 5'h01, 8'h00, mem_mdl[5'h01], 1'b0, lat);
        do_req(1'b0, 5'h09, 8'h00, mem_mdl[5'h09], 1'b0, lat);
        do_req(1'b0, 5'h11, 8'h00, mem_mdl[5'h11], 1'b0, lat);
        do_req(1'b0, 5'h09, 8'h00, mem_mdl[5'h09], 1'b1, lat);
        do_req(1'b0, 5'h01, 8'h00, mem_mdl[5'h01], 1'b0, lat);
        n_vec++; if (hit_count !== 16'd1 || miss_count !== 16'd4)
            begin n_err++; $display("FAIL lru_counts: hit=%0d miss=%0d expected 1/4", hit_count, miss_count); end
    endtask

`ifdef ASSOC_CACHE_WRITEBACK_EN
    task automatic test_write();
        int lat;
        do_reset();
        do_req(1'b1, 5'h02, 8'hAA, 8'hAA, 1'b0, lat);
        mem_log.delete();
        do_req(1'b0, 5'h0A, 8'h00, mem_mdl[5'h0A], 1'b0, lat);
        do_req(1'b0, 5'h12, 8'h00, mem_mdl[5'h12], 1'b0, lat);
        n_vec++;
        if (mem_log.size() != 3) begin
            n_err++; $display("FAIL wb_log_size: got %0d expected 3", mem_log.size());
        end else begin
            if (!(mem_log[1].we === 1'b1 && mem_log[1].addr === 5'h02 && mem_log[1].data === 8'hAA)) begin
                n_err++; $display("FAIL wb_write: we=%b addr=%h data=%h expected 1/02/aa", mem_log[1].we, mem_log[1].addr, mem_log[1].data);
            end
            n_vec++;
            if (!(mem_log[2].we === 1'b0 && mem_log[2].addr === 5'h12)) begin
                n_err++; $display("FAIL wb_refill_after: we=%b addr=%h expected 0/12", mem_log[2].we, mem_log[2].addr);
            end
        end
    endtask
`else
    task automatic test_write();
        int lat;
        int writes;
        do_reset();
        do_req(1'b0, 5'h03, 8'h00, mem_mdl[5'h03], 1'b0, lat);
        mem_log.delete();
        do_req(1'b1, 5'h03, 8'h55, 8'h55, 1'b1, lat);
        n_vec++;
        if (log_at_resp != 1 || mem_log.size() != 1) begin
            n_err++; $display("FAIL wt_hit_log: at_resp=%0d total=%0d expected 1/1", log_at_resp, mem_log.size());
        end else if (!(mem_log[0].we === 1'b1 && mem_log[0].addr === 5'h03 && mem_log[0].data === 8'h55)) begin
            n_err++; $display("FAIL wt_hit_write: we=%b addr=%h data=%h expected 1/03/55", mem_log[0].we, mem_log[0].addr, mem_log[0].data);
        end
        do_req(1'b0, 5'h0B, 8'h00, mem_mdl[5'h0B], 1'b0, lat);
        do_req(1'b0, 5'h13, 8'h00, mem_mdl[5'h13], 1'b0, lat);
        writes = 0;
        foreach (mem_log[i]) if (mem_log[i].we) writes++;
        n_vec++; if (writes != 1) begin n_err++; $display("FAIL wt_no_writeback: got %0d writes expected 1", writes); end
        do_req(1'b0, 5'h03, 8'h00, 8'h55, 1'b0, lat);
        mem_log.delete();
        do_req(1'b1, 5'h1F, 8'h77, 8'h77, 1'b0, lat);
        n_vec++;
        if (mem_log.size() != 2 || log_at_resp != 2) begin
            n_err++; $display("FAIL wt_miss_log: total=%0d at_resp=%0d expected 2/2", mem_log.size(), log_at_resp);
        end else if (!(mem_log[0].we === 1'b0 && mem_log[1].we === 1'b1 && mem_log[1].addr === 5'h1F && mem_log[1].data === 8'h77)) begin
            n_err++; $display("FAIL wt_miss_order: op0 we=%b op1 we=%b addr=%h data=%h expected 0 then 1/1f/77",
                              mem_log[0].we, mem_log[1].we, mem_log[1].addr, mem_log[1].data);
        end
    endtask
`endif

    task automatic test_reset_mid();
        int lat;
        bit seen;
        do_reset();
        do_req(1'b0, 5'h05, 8'h00, mem_mdl[5'h05], 1'b0, lat);
        ack_hold = 1'b1;
        send_req(1'b0, 5'h06, 8'h00, mem_mdl[5'h06], 1'b0);
        wait_mem_req();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        n_vec++; if (mem_req !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0)
            begin n_err++; $display("FAIL mid_reset_state: mem_req=%b req_ready=%b resp_valid=%b expected 0/1/0", mem_req, req_ready, resp_valid); end
        @(negedge clock);
        reset    = 1'b0;
        ack_hold = 1'b0;
        exp_q.delete();
        seen = 1'b0;
        repeat (5) begin
            @(negedge clock);
            if (resp_valid) seen = 1'b1;
        end
        n_vec++; if (seen) begin n_err++; $display("FAIL mid_reset_resp: resp_valid seen=1 expected 0"); end
        do_req(1'b0, 5'h05, 8'h00, mem_mdl[5'h05], 1'b0, lat);
        n_vec++; if (miss_count !== 16'd1 || hit_count !== 16'd0)
            begin n_err++; $display("FAIL mid_reset_counts: hit=%0d miss=%0d expected 0/1", hit_count, miss_count); end
    endtask

    task automatic test_stall();
        int lat;
        ack_hold = 1'b1;
        send_req(1'b0, 5'h1A, 8'h00, mem_mdl[5'h1A], 1'b0);
        wait_mem_req();
        repeat (10) begin
            @(negedge clock);
            n_vec++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 5'h1A || req_ready !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold: mem_req=%b mem_we=%b mem_addr=%h req_ready=%b expected 1/0/1a/0",
                         mem_req, mem_we, mem_addr, req_ready);
            end
        end
        ack_hold = 1'b0;
        wait_resp(lat);
    endtask

    task automatic test_back_to_back();
        int lat;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            ack_delay = int'($urandom_range(0, 3));
            do_req(1'b0, 5'(i), 8'h00, mem_mdl[i], 1'b0, lat);
        end
        for (int i = 0; i < 8; i++) begin
            do_req(1'b0, 5'(i), 8'h00, mem_mdl[i], 1'b1, lat);
            n_vec++; if (lat != 2) begin n_err++; $display("FAIL b2b_hit_latency: addr %0d got %0d expected 2", i, lat); end
        end
        ack_delay = 0;
        n_vec++; if (hit_count !== 16'd8 || miss_count !== 16'd8)
            begin n_err++; $display("FAIL b2b_counts: hit=%0d miss=%0d expected 8/8", hit_count, miss_count); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem_mdl[i] = 8'(i * 7 + 3);
        mem_mdl[5'h0A] = 8'h3C;
        test_reset();
        test_miss_then_hit();
        test_lru();
        test_write();
        test_reset_mid();
        test_stall();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/assoc_cache_ctrl.md
ASSOC_CACHE_CTRL -- requirements
Module: assoc_cache_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W, 5, word address width.
REQ-002 SET_BITS, 3, index width; SETS = 2**SET_BITS; TAG_W = ADDR_W-SET_BITS (must be >=1).
REQ-003 DATA_W, 8, data word width.
REQ-004 CNT_W, 16, width of hit/miss statistic counters.
REQ-005 Ports SHALL be: clock input 1, clock; reset input 1, reset, synchronous, active-high.
REQ-006 req_valid in 1; req_ready out 1; req_we in 1; req_addr in ADDR_W; req_wdata in DATA_W: CPU request channel.
REQ-007 resp_valid out 1, one-cycle pulse; resp_rdata out DATA_W; resp_hit out 1: CPU response.
REQ-008 mem_req out 1; mem_we out 1; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_ack in 1; mem_rdata in DATA_W: backing-memory channel.
REQ-009 hit_count out CNT_W; miss_count out CNT_W: statistics.

Function
REQ-010 Cache SHALL be 2-way set-associative, one word per line; per way per set: valid, dirty, tag[TAG_W], data[DATA_W]; one LRU bit per set.
REQ-011 Index = req_addr[SET_BITS-1:0]; tag = req_addr[ADDR_W-1:SET_BITS].
REQ-012 FSM states SHALL be IDLE, LOOKUP, WRITEBACK, REFILL, WTHRU, RESPOND.
REQ-013 IDLE: req_ready=1; handshake req_valid&&req_ready latches addr/we/wdata, moves to LOOKUP; req_ready=0 in all other states.
REQ-014 LOOKUP hit (valid && tag match in either way): read returns way data; write updates data; -> RESPOND (or WTHRU, REQ-027); resp_hit=1.
REQ-015 Hit latency: resp_valid asserted exactly 2 cycles after accept cycle.
REQ-016 Both ways matching SHALL not occur; if forced, way 0 wins.
REQ-017 Miss victim: first invalid way (way 0 priority), else way selected by LRU bit.
REQ-018 Miss with victim valid&&dirty -> WRITEBACK, else -> REFILL.
REQ-019 WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag,index}, mem_wdata=victim data, held until mem_ack; then -> REFILL.
REQ-020 REFILL: mem_req=1, mem_we=0, mem_addr=request address, held until mem_ack; on ack install mem_rdata (or req_wdata for write) in victim, valid=1, tag updated, dirty=req_we; -> RESPOND.
REQ-021 RESPOND: resp_valid=1 one cycle, resp_rdata=line data, resp_hit as determined in LOOKUP; -> IDLE.
REQ-022 LRU bit SHALL point to the way not accessed, updated on every hit and every install.
REQ-023 mem_ack outside WRITEBACK/REFILL/WTHRU SHALL be ignored; mem outputs deasserted in IDLE/LOOKUP/RESPOND.
REQ-024 hit_count/miss_count SHALL increment once per LOOKUP outcome, saturating at all-ones.
REQ-025 resp_rdata SHALL hold its last value between responses.

Reset
REQ-026 On reset: FSM->IDLE, all valid/dirty/LRU=0, counters=0, resp_valid=0, resp_hit=0, resp_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; reset mid-transaction abandons it without response; data arrays need not clear.

Configuration
REQ-027 ASSOC_CACHE_WRITEBACK_EN defined: write-back, dirty bits kept, WRITEBACK state used, WTHRU unreachable. Undefined: write-through write-allocate, dirty never set, WRITEBACK unreachable, every write (after hit update or refill) enters WTHRU issuing mem write of request addr/data until mem_ack, then RESPOND.

Structure
REQ-028 Package assoc_cache_pkg SHALL hold FSM state enum and line record type (valid, dirty, tag, data) parametrised by widths via localparams/defaults.
REQ-029 One sub-module cache_way SHALL hold one way's SETS-entry line storage with synchronous write, combinational read; instantiated twice.

Verification
REQ-030 Reset, read addr 5'h0A, mem_rdata 8'h3C -> miss, miss_count=1, resp_rdata=8'h3C, resp_hit=0; reread 5'h0A -> hit at +2 cycles, hit_count=1.
REQ-031 Read 5'h01 then 5'h09 (same set, tags 0/1) then 5'h11 -> third evicts way holding 5'h01 (LRU); reread 5'h09 hits, 5'h01 misses.
REQ-032 WRITEBACK_EN: write 8'hAA to 5'h02, fill set with 5'h0A, 5'h12 -> mem write addr 5'h02 data 8'hAA precedes refill read.
REQ-033 Without macro: write hit 8'h55 to cached 5'h03 -> mem write 5'h03/8'h55 before resp_valid; no later writeback.
REQ-034 Assert reset while REFILL waits mem_ack -> next cycle IDLE, mem_req=0, no resp_valid, prior lines all miss.
REQ-035 Hold mem_ack low 10 cycles in REFILL -> mem_req/mem_addr stable, req_ready=0 throughout.
